// File: rtl/byte_pair_packer.sv
// Collects a valid/ready byte stream into ordered hi/lo byte pairs, padding odd or stalled pairs.
// Optional statistics counters are enabled by defining BYTE_PAIR_STATS_EN.
`timescale 1ns/1ps

module byte_pair_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_hi,
  output logic [7:0]  m_lo,
  output logic        m_partial,
  output logic [15:0] pair_cnt,
  output logic [15:0] pad_cnt
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HALF, FULL} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    hi_d, lo_d;
  logic          partial_d, valid_d;
  logic          accept;
  logic          take_first;

  // A held pair only blocks input when downstream is not draining it this cycle.
  assign s_ready    = (state_q != FULL) | m_ready;
  assign accept     = s_valid & s_ready;
  assign take_first = accept & ((state_q == IDLE) | (state_q == FULL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      m_valid   <= 1'b0;
      m_hi      <= 8'h00;
      m_lo      <= 8'h00;
      m_partial <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      m_valid   <= valid_d;
      m_hi      <= hi_d;
      m_lo      <= lo_d;
      m_partial <= partial_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    valid_d   = m_valid;
    hi_d      = m_hi;
    lo_d      = m_lo;
    partial_d = m_partial;

    case (state_q)
      IDLE: ;
      HALF: begin
        if (accept) begin
          lo_d      = s_data;
          partial_d = 1'b0;
          state_d   = FULL;
          valid_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
          if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
            lo_d      = PAD_BYTE;
            partial_d = 1'b1;
            state_d   = FULL;
            valid_d   = 1'b1;
          end
        end
      end
      FULL: begin
        if (m_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // First byte of a pair, from IDLE or while the previous pair drains.
    if (take_first) begin
      hi_d = s_data;
      if (s_last) begin
        lo_d      = PAD_BYTE;
        partial_d = 1'b1;
        state_d   = FULL;
        valid_d   = 1'b1;
      end else begin
        timer_d = '0;
        state_d = HALF;
        valid_d = 1'b0;
      end
    end
  end

`ifdef BYTE_PAIR_STATS_EN
  logic handshake;
  assign handshake = m_valid & m_ready;

  // Saturating delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= 16'h0000;
      pad_cnt  <= 16'h0000;
    end else if (handshake) begin
      if (pair_cnt != 16'hFFFF) pair_cnt <= pair_cnt + 16'd1;
      if (m_partial && (pad_cnt != 16'hFFFF)) pad_cnt <= pad_cnt + 16'd1;
    end
  end
`else
  assign pair_cnt = 16'h0000;
  assign pad_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed self-checking bench for byte_pair_packer (TIMEOUT_CYCLES=16, PAD_BYTE=0x00).
`timescale 1ns/1ps

module tb_byte_pair_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_hi;
  logic [7:0]  m_lo;
  logic        m_partial;
  logic [15:0] pair_cnt;
  logic [15:0] pad_cnt;

  int n_checks = 0;
  int n_errors = 0;

  byte_pair_packer #(.TIMEOUT_CYCLES(16), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_hi(m_hi), .m_lo(m_lo),
    .m_partial(m_partial), .pair_cnt(pair_cnt), .pad_cnt(pad_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic check_pair(input string tag, input logic v, input logic [7:0] hi,
                            input logic [7:0] lo, input logic p);
    check({tag, ".valid"}, 32'(m_valid), 32'(v));
    if (v) begin
      check({tag, ".hi"}, 32'(m_hi), 32'(hi));
      check({tag, ".lo"}, 32'(m_lo), 32'(lo));
      check({tag, ".partial"}, 32'(m_partial), 32'(p));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    check("rst.valid", 32'(m_valid), 32'd0);
    check("rst.hi", 32'(m_hi), 32'd0);
    check("rst.lo", 32'(m_lo), 32'd0);
    check("rst.partial", 32'(m_partial), 32'd0);
    check("rst.s_ready", 32'(s_ready), 32'd1);
    check("rst.pair_cnt", 32'(pair_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back pair 0x10,0x20
    drive(1'b1, 8'h10, 1'b0); tick();
    check_pair("t1.half", 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h20, 1'b0); tick();
    check_pair("t1.pair", 1'b1, 8'h10, 8'h20, 1'b0);
    drive(1'b0, 8'h00, 1'b0); tick();
    check_pair("t1.drained", 1'b0, 8'h00, 8'h00, 1'b0);

    // 2: single byte with last -> padded
    drive(1'b1, 8'hAB, 1'b1); tick();
    check_pair("t2.pad", 1'b1, 8'hAB, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0); tick();
    check_pair("t2.drained", 1'b0, 8'h00, 8'h00, 1'b0);

    // 3a: timeout exactly 16 cycles after entering HALF
    drive(1'b1, 8'h55, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (15) tick();
    check_pair("t3.before_expiry", 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check_pair("t3.expired", 1'b1, 8'h55, 8'h00, 1'b1);
    tick();
    check_pair("t3.drained", 1'b0, 8'h00, 8'h00, 1'b0);

    // 3b: byte on the expiry cycle wins over padding
    drive(1'b1, 8'h66, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (15) tick();
    check_pair("t3b.before_expiry", 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h77, 1'b0); tick();
    check_pair("t3b.byte_wins", 1'b1, 8'h66, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b0); tick();

    // 4: backpressure then full-throughput release
    m_ready = 1'b0;
    drive(1'b1, 8'h01, 1'b0); tick();
    drive(1'b1, 8'h02, 1'b0); tick();
    check_pair("t4.held", 1'b1, 8'h01, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0); #1;
    check("t4.s_ready_low", 32'(s_ready), 32'd0);
    repeat (3) tick();
    check_pair("t4.stable", 1'b1, 8'h01, 8'h02, 1'b0);
    m_ready = 1'b1; #1;
    check("t4.s_ready_high", 32'(s_ready), 32'd1);
    tick();
    check_pair("t4.p1_taken", 1'b0, 8'h00, 8'h00, 1'b0);
    check("t4.hi03", 32'(m_hi), 32'h03);
    drive(1'b1, 8'h04, 1'b0); tick();
    check_pair("t4.p2", 1'b1, 8'h03, 8'h04, 1'b0);
    drive(1'b1, 8'h05, 1'b0); tick();
    check_pair("t4.p2_taken", 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h06, 1'b0); tick();
    check_pair("t4.p3", 1'b1, 8'h05, 8'h06, 1'b0);
    drive(1'b0, 8'h00, 1'b0); tick();
    check_pair("t4.drained", 1'b0, 8'h00, 8'h00, 1'b0);

    // 5: async reset in HALF discards the held byte
    drive(1'b1, 8'h77, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    check("t5.hi_before", 32'(m_hi), 32'h77);
    #1 rst_n = 1'b0;
    #1;
    check("t5.valid", 32'(m_valid), 32'd0);
    check("t5.hi", 32'(m_hi), 32'd0);
    check("t5.pair_cnt", 32'(pair_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 8'h88, 1'b0); tick();
    check_pair("t5.half", 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h99, 1'b0); tick();
    check_pair("t5.post_reset_pair", 1'b1, 8'h88, 8'h99, 1'b0);

    // 6: continue streaming: two more full pairs (last ignored in HALF), two padded
    drive(1'b1, 8'hA1, 1'b0); tick();
    drive(1'b1, 8'hA2, 1'b1); tick();
    check_pair("t6.pairA", 1'b1, 8'hA1, 8'hA2, 1'b0);
    drive(1'b1, 8'hB1, 1'b0); tick();
    drive(1'b1, 8'hB2, 1'b0); tick();
    check_pair("t6.pairB", 1'b1, 8'hB1, 8'hB2, 1'b0);
    drive(1'b1, 8'hC1, 1'b1); tick();
    check_pair("t6.padC", 1'b1, 8'hC1, 8'h00, 1'b1);
    drive(1'b1, 8'hD1, 1'b1); tick();
    check_pair("t6.padD", 1'b1, 8'hD1, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0); tick();
    check_pair("t6.drained", 1'b0, 8'h00, 8'h00, 1'b0);
`ifdef BYTE_PAIR_STATS_EN
    check("t6.pair_cnt", 32'(pair_cnt), 32'd5);
    check("t6.pad_cnt", 32'(pad_cnt), 32'd2);
`else
    check("t6.pair_cnt", 32'(pair_cnt), 32'd0);
    check("t6.pad_cnt", 32'(pad_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
